frame_buffer_manager: RTL and testbench
=======================================

# frame_buffer_manager

Parametrised N-buffer (double or triple) frame store arbitrating between one pixel producer (UART streaming controller) and one pixel consumer (ILI9341 display controller). Owns the buffer RAMs, steers producer writes to the back buffer and consumer reads to the front buffer, and performs frame-synchronous swaps. Triple mode lets the producer run without stalling, dropping stale completed frames. Sits between the streaming controller and the display controller in the top level.

## Interface
- NUM_BUFS, 2, buffer count; legal values 2 or 3
- DATA_WIDTH, 8, RAM word width
- DEPTH, 2400, words per buffer
- ADDR_WIDTH, 32, address port width; only the low clog2(DEPTH) bits are used
- INIT_FILE, "", optional hex init for buffer 0
- clk  in  1  system clock; only clock
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  producer write strobe
- wr_addr  in  ADDR_WIDTH  producer word address
- wr_data  in  DATA_WIDTH  producer data
- wr_done  in  1  one-cycle pulse: back buffer holds a complete frame
- wr_ready  out  1  back buffer is writable
- rd_addr  in  ADDR_WIDTH  consumer word address
- rd_data  out  DATA_WIDTH  front-buffer data, 1-cycle latency
- rd_frame_end  in  1  one-cycle pulse: consumer finished scanning a frame
- front_idx  out  2  current front buffer index
- swap_pending  out  1  completed frame waiting for rd_frame_end
- swap_count  out  16  swaps performed, wraps
- drop_count  out  8  completed frames discarded unseen, saturates at 255

## Operation
- State: front, back, spare indices (2-bit each); pend_valid (completed frame held in spare, triple mode only); stall (double mode only).
- Reset values: front=0, back=1, spare=2, pend_valid=0, stall=0, wr_ready=1, swap_pending=0, swap_count=0, drop_count=0, rd_data=0.
- wr_en with wr_ready=1 writes wr_data to buffer back at wr_addr. wr_en with wr_ready=0 is ignored. Writes never touch the front buffer.
- Double mode (NUM_BUFS=2):
  - wr_done alone: stall=1, wr_ready=0, swap_pending=1.
  - rd_frame_end with stall=1, or simultaneous with wr_done: swap front and back; stall=0; wr_ready=1; swap_count+1.
  - rd_frame_end with no completed frame: no change.
  - wr_done while stall=1 is ignored. The producer must not assert it, and there is no drop in double mode.
- Triple mode (NUM_BUFS=3); wr_ready is constantly 1:
  - wr_done alone with pend_valid=0: swap back and spare; pend_valid=1.
  - wr_done alone with pend_valid=1: swap back and spare (old pending frame becomes the new back); drop_count+1.
  - rd_frame_end alone with pend_valid=1: swap front and spare; pend_valid=0; swap_count+1.
  - rd_frame_end alone with pend_valid=0: no change.
  - Simultaneous wr_done and rd_frame_end: front←old back, back←old spare, spare←old front, pend_valid=0, swap_count+1. If pend_valid was 1, drop_count+1.
- swap_pending = stall (double mode) or pend_valid (triple mode).
- A write in the same cycle as wr_done lands in the old back buffer.

## Timing
- Index updates are registered and take effect on the clk edge after the pulse.
- rd_addr sampled at edge N returns data at edge N+1. The bank select for rd_data uses front registered alongside the address. A read issued in the rd_frame_end cycle therefore returns old-front data.
- wr_ready falls on the edge after wr_done and rises on the edge after the swapping rd_frame_end. Writes are committed on the edge where wr_en is sampled.
- Reset deassertion is not synchronised inside the block; the top level supplies a synchronised release.

## Structure
- The shared package holds buffer-index constants (BUF0..BUF2) and the clog2 address-width helper.
- Sub-module buffer_swap_ctrl holds the index and pend/stall state machine plus the counters, with no RAM.
- The top of this block instantiates NUM_BUFS single_port_ram banks and the read/write muxes.

## Test plan
- Reset, then write 0xA5 at addr 3, read addr 3 → rd_data=init value of buffer 0 (front untouched); after wr_done + rd_frame_end, reading addr 3 → 0xA5.
- Double mode, wr_done then 10 cycles, then rd_frame_end → wr_ready low for exactly 10 cycles plus 1; writes during the stall leave RAM unchanged; swap_count=1.
- Double mode, simultaneous wr_done and rd_frame_end → immediate swap, wr_ready never drops, front_idx=1.
- Triple mode, three wr_done pulses with no rd_frame_end → drop_count=2, wr_ready=1 throughout; next rd_frame_end → front shows the third frame, swap_count=1.
- Triple mode, simultaneous wr_done/rd_frame_end with pend_valid=1 → front=old back, drop_count+1, pend_valid=0.
- Assert reset mid-stall with a pending frame → all outputs return to reset values asynchronously; the next write lands in buffer 1.

Source files
------------

// File: rtl/frame_buffer_manager_pkg.sv
// Shared buffer-index constants and address-width helper for the frame buffer manager.
package frame_buffer_manager_pkg;

  localparam logic [1:0] BUF0 = 2'd0;
  localparam logic [1:0] BUF1 = 2'd1;
  localparam logic [1:0] BUF2 = 2'd2;

  // Address bits needed to cover depth words (at least one bit).
  function automatic int addr_bits(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) w++;
    return w;
  endfunction

endpackage

// File: rtl/frame_buffer_manager_ram.sv
// One frame buffer bank: single port, write-first-ignored (read-first), registered read
// with an async-cleared output so rd_data comes up as zero.
module single_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2400,
  parameter int AW         = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) o_rdata <= '0;
    else        o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/frame_buffer_manager_swap_ctrl.sv
// Buffer role state machine: front/back(/spare) indices, stall or pending flag,
// swap and drop counters. No storage of pixel data.
module buffer_swap_ctrl
  import frame_buffer_manager_pkg::*;
#(
  parameter int NUM_BUFS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wr_done,
  input  logic        i_rd_frame_end,
  output logic [1:0]  o_front,
  output logic [1:0]  o_back,
  output logic        o_wr_ready,
  output logic        o_swap_pending,
  output logic [15:0] o_swap_count,
  output logic [7:0]  o_drop_count
);

  logic [1:0]  r_front, r_back;
  logic [15:0] r_swap_cnt;
  logic [7:0]  r_drop_cnt;
  logic        w_swap, w_drop;

  if (NUM_BUFS == 3) begin : g_triple
    logic [1:0] r_spare;
    logic       r_pend;

    assign w_swap         = i_rd_frame_end & (i_wr_done | r_pend);
    assign w_drop         = i_wr_done & r_pend;
    assign o_wr_ready     = 1'b1;
    assign o_swap_pending = r_pend;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_front <= BUF0;
        r_back  <= BUF1;
        r_spare <= BUF2;
        r_pend  <= 1'b0;
      end else if (i_wr_done && i_rd_frame_end) begin
        // Fresh frame goes straight to display; any pending frame is recycled.
        r_front <= r_back;
        r_back  <= r_spare;
        r_spare <= r_front;
        r_pend  <= 1'b0;
      end else if (i_wr_done) begin
        r_back  <= r_spare;
        r_spare <= r_back;
        r_pend  <= 1'b1;
      end else if (i_rd_frame_end && r_pend) begin
        r_front <= r_spare;
        r_spare <= r_front;
        r_pend  <= 1'b0;
      end
    end
  end else begin : g_double
    logic r_stall;
    logic w_done;

    // A second completion while stalled is ignored.
    assign w_done         = i_wr_done & ~r_stall;
    assign w_swap         = i_rd_frame_end & (r_stall | w_done);
    assign w_drop         = 1'b0;
    assign o_wr_ready     = ~r_stall;
    assign o_swap_pending = r_stall;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_front <= BUF0;
        r_back  <= BUF1;
        r_stall <= 1'b0;
      end else if (w_swap) begin
        r_front <= r_back;
        r_back  <= r_front;
        r_stall <= 1'b0;
      end else if (w_done) begin
        r_stall <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_swap_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_swap) r_swap_cnt <= r_swap_cnt + 16'd1;
      if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign o_front      = r_front;
  assign o_back       = r_back;
  assign o_swap_count = r_swap_cnt;
  assign o_drop_count = r_drop_cnt;

endmodule

// File: rtl/frame_buffer_manager.sv
// N-buffer (2 or 3) frame store: producer writes the back buffer, consumer reads the
// front buffer, roles swap on frame boundaries. INIT_FILE preload is left to the RAM flow.
module frame_buffer_manager
  import frame_buffer_manager_pkg::*;
#(
  parameter int    NUM_BUFS   = 2,
  parameter int    DATA_WIDTH = 8,
  parameter int    DEPTH      = 2400,
  parameter int    ADDR_WIDTH = 32,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_done,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_frame_end,
  output logic [1:0]            front_idx,
  output logic                  swap_pending,
  output logic [15:0]           swap_count,
  output logic [7:0]            drop_count
);

  localparam int AW = addr_bits(DEPTH);

  logic [1:0]                           w_front, w_back, r_rd_sel;
  logic                                 w_wr_ready;
  logic [AW-1:0]                        w_wr_addr, w_rd_addr;
  logic [NUM_BUFS-1:0][DATA_WIDTH-1:0]  w_bank_q;
  logic                                 w_unused_addr_hi;

  assign w_wr_addr        = wr_addr[AW-1:0];
  assign w_rd_addr        = rd_addr[AW-1:0];
  assign w_unused_addr_hi = ^{wr_addr[ADDR_WIDTH-1:AW], rd_addr[ADDR_WIDTH-1:AW]};

  buffer_swap_ctrl #(.NUM_BUFS(NUM_BUFS)) u_ctrl (
    .clk            (clk),
    .reset          (reset),
    .i_wr_done      (wr_done),
    .i_rd_frame_end (rd_frame_end),
    .o_front        (w_front),
    .o_back         (w_back),
    .o_wr_ready     (w_wr_ready),
    .o_swap_pending (swap_pending),
    .o_swap_count   (swap_count),
    .o_drop_count   (drop_count)
  );

  // Front and back are always distinct, so each bank needs only one port:
  // the back bank sees the write address, every other bank the read address.
  for (genvar g = 0; g < NUM_BUFS; g++) begin : g_bank
    logic w_is_back;
    assign w_is_back = (w_back == 2'(g));

    single_port_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk     (clk),
      .reset   (reset),
      .i_we    (wr_en & w_wr_ready & w_is_back),
      .i_addr  (w_is_back ? w_wr_addr : w_rd_addr),
      .i_wdata (wr_data),
      .o_rdata (w_bank_q[g])
    );
  end

  // Bank select travels with the read address, so a swap never tears a read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rd_sel <= BUF0;
    else        r_rd_sel <= w_front;
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_BUFS; i++)
      if (r_rd_sel == 2'(i)) rd_data = w_bank_q[i];
  end

  assign wr_ready  = w_wr_ready;
  assign front_idx = w_front;

endmodule

// File: tb/tb_frame_buffer_manager.sv
// Bench: one double-buffer and one triple-buffer instance share stimulus; a role/memory
// model per instance predicts every output.
module tb_frame_buffer_manager;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        wr_en, wr_done, rd_frame_end;
  logic [31:0] wr_addr, rd_addr;
  logic [7:0]  wr_data;

  logic        d_ready [2];
  logic [7:0]  d_rd    [2];
  logic [1:0]  d_front [2];
  logic        d_pend  [2];
  logic [15:0] d_swaps [2];
  logic [7:0]  d_drops [2];

  frame_buffer_manager #(.NUM_BUFS(2), .DATA_WIDTH(8), .DEPTH(DEPTH), .ADDR_WIDTH(32), .INIT_FILE("")) u_dbl (
    .clk(clk), .reset(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_done(wr_done), .wr_ready(d_ready[0]), .rd_addr(rd_addr), .rd_data(d_rd[0]),
    .rd_frame_end(rd_frame_end), .front_idx(d_front[0]), .swap_pending(d_pend[0]),
    .swap_count(d_swaps[0]), .drop_count(d_drops[0]));

  frame_buffer_manager #(.NUM_BUFS(3), .DATA_WIDTH(8), .DEPTH(DEPTH), .ADDR_WIDTH(32), .INIT_FILE("")) u_tri (
    .clk(clk), .reset(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_done(wr_done), .wr_ready(d_ready[1]), .rd_addr(rd_addr), .rd_data(d_rd[1]),
    .rd_frame_end(rd_frame_end), .front_idx(d_front[1]), .swap_pending(d_pend[1]),
    .swap_count(d_swaps[1]), .drop_count(d_drops[1]));

  // Reference model: index 0 = double buffering, 1 = triple buffering.
  logic [7:0] m_mem [2][3][DEPTH];
  int         m_front [2], m_back [2], m_spare [2];
  bit         m_pend [2];
  int         m_swaps [2], m_drops [2];
  logic [7:0] m_rd [2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_front[m] = 0; m_back[m] = 1; m_spare[m] = 2;
      m_pend[m] = 1'b0; m_swaps[m] = 0; m_drops[m] = 0; m_rd[m] = 8'h00;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      int f, b, s;
      f = m_front[m]; b = m_back[m]; s = m_spare[m];
      m_rd[m] = m_mem[m][f][rd_addr[3:0]];
      if (wr_en && (m == 1 || !m_pend[m])) m_mem[m][b][wr_addr[3:0]] = wr_data;
      if (m == 0) begin
        if (rd_frame_end && (m_pend[0] || wr_done)) begin
          m_front[0] = b; m_back[0] = f; m_pend[0] = 1'b0; m_swaps[0]++;
        end else if (wr_done) m_pend[0] = 1'b1;
      end else begin
        if (wr_done && m_pend[1]) m_drops[1] = (m_drops[1] < 255) ? m_drops[1] + 1 : 255;
        if (wr_done && rd_frame_end) begin
          m_front[1] = b; m_back[1] = s; m_spare[1] = f; m_pend[1] = 1'b0; m_swaps[1]++;
        end else if (wr_done) begin
          m_back[1] = s; m_spare[1] = b; m_pend[1] = 1'b1;
        end else if (rd_frame_end && m_pend[1]) begin
          m_front[1] = s; m_spare[1] = f; m_pend[1] = 1'b0; m_swaps[1]++;
        end
      end
    end
  endtask

  function automatic logic [35:0] m_vec(input int m);
    logic rdy;
    rdy = (m == 1) ? 1'b1 : !m_pend[m];
    return {2'(m_front[m]), rdy, m_pend[m], 16'(m_swaps[m]), 8'(m_drops[m]), m_rd[m]};
  endfunction

  function automatic logic [35:0] d_vec(input int m);
    return {d_front[m], d_ready[m], d_pend[m], d_swaps[m], d_drops[m], d_rd[m]};
  endfunction

  task automatic idle();
    wr_en = 0; wr_done = 0; rd_frame_end = 0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Fill every word of every bank with known data; RAM contents survive reset.
  task automatic prime();
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < DEPTH; a++) begin
        wr_en = 1; wr_addr = 32'(a); wr_data = 8'($urandom);
        tick();
      end
      idle(); wr_done = 1; rd_frame_end = 1;
      tick();
      idle();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (d_vec(m) !== 36'({2'd0, 1'b1, 1'b0, 16'd0, 8'd0, 8'd0})) begin
        n_errors++; $display("FAIL reset[%0d] got %h want %h", m, d_vec(m), {2'd0, 1'b1, 1'b0, 16'd0, 8'd0, 8'd0});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_front_untouched();
    logic [7:0] exp0 [2];
    for (int m = 0; m < 2; m++) exp0[m] = m_mem[m][0][3];
    wr_en = 1; wr_addr = 32'd3; wr_data = 8'hA5; tick(); idle();
    rd_addr = 32'd3; tick();
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (d_rd[m] !== exp0[m]) begin
        n_errors++; $display("FAIL front_untouched[%0d] got %h want %h", m, d_rd[m], exp0[m]);
      end
    end
    idle(); wr_done = 1; rd_frame_end = 1; tick(); idle();
    rd_addr = 32'd3; tick(); idle();
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (d_rd[m] !== 8'hA5) begin
        n_errors++; $display("FAIL swapped_read[%0d] got %h want a5", m, d_rd[m]);
      end
    end
  endtask

  task automatic test_double_stall();
    int lows;
    logic [7:0] keep [10];
    do_reset();
    for (int k = 0; k < 10; k++) keep[k] = m_mem[0][1][k];
    lows = 0;
    wr_done = 1; tick(); idle();
    if (!d_ready[0]) lows++;
    for (int k = 0; k < 10; k++) begin
      wr_en = 1; wr_addr = 32'(k); wr_data = ~keep[k];
      tick();
      if (!d_ready[0]) lows++;
    end
    idle(); rd_frame_end = 1; tick(); idle();
    if (!d_ready[0]) lows++;
    n_checks++;
    if (lows != 11) begin n_errors++; $display("FAIL stall_len got %0d want 11", lows); end
    n_checks++;
    if (d_swaps[0] !== 16'd1 || d_front[0] !== 2'd1) begin
      n_errors++; $display("FAIL stall_swap got cnt %0d front %0d want 1 1", d_swaps[0], d_front[0]);
    end
    for (int k = 0; k < 10; k++) begin
      rd_addr = 32'(k); tick();
      n_checks++;
      if (d_rd[0] !== keep[k]) begin
        n_errors++; $display("FAIL stall_write_ignored a%0d got %h want %h", k, d_rd[0], keep[k]);
      end
    end
    idle();
  endtask

  task automatic test_double_simul();
    do_reset();
    wr_done = 1; rd_frame_end = 1; tick(); idle();
    n_checks++;
    if ({d_ready[0], d_pend[0], d_front[0], d_swaps[0]} !== {1'b1, 1'b0, 2'd1, 16'd1}) begin
      n_errors++; $display("FAIL dbl_simul got rdy %b pend %b front %0d cnt %0d want 1 0 1 1",
                           d_ready[0], d_pend[0], d_front[0], d_swaps[0]);
    end
  endtask

  task automatic test_triple_drop();
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      wr_en = 1; wr_addr = 32'd5; wr_data = 8'(8'h10 + k); tick();
      idle(); wr_done = 1; tick(); idle();
      n_checks++;
      if (d_ready[1] !== 1'b1) begin n_errors++; $display("FAIL tri_ready frame%0d got %b want 1", k, d_ready[1]); end
    end
    n_checks++;
    if (d_drops[1] !== 8'd2 || d_pend[1] !== 1'b1) begin
      n_errors++; $display("FAIL tri_drops got %0d pend %b want 2 1", d_drops[1], d_pend[1]);
    end
    rd_frame_end = 1; tick(); idle();
    rd_addr = 32'd5; tick(); idle();
    n_checks++;
    if ({d_rd[1], d_front[1], d_swaps[1]} !== {8'h13, 2'd1, 16'd1}) begin
      n_errors++; $display("FAIL tri_show_third got data %h front %0d cnt %0d want 13 1 1", d_rd[1], d_front[1], d_swaps[1]);
    end
  endtask

  task automatic test_triple_simul();
    do_reset();
    wr_done = 1; tick(); idle();
    wr_done = 1; rd_frame_end = 1; tick(); idle();
    n_checks++;
    if ({d_front[1], d_drops[1], d_pend[1], d_swaps[1]} !== {2'd2, 8'd1, 1'b0, 16'd1}) begin
      n_errors++; $display("FAIL tri_simul got front %0d drop %0d pend %b cnt %0d want 2 1 0 1",
                           d_front[1], d_drops[1], d_pend[1], d_swaps[1]);
    end
  endtask

  task automatic test_drop_saturate();
    do_reset();
    wr_done = 1;
    repeat (260) tick();
    idle();
    n_checks++;
    if (d_drops[1] !== 8'd255) begin n_errors++; $display("FAIL drop_sat got %0d want 255", d_drops[1]); end
  endtask

  task automatic test_reset_midstall();
    do_reset();
    wr_done = 1; rd_frame_end = 1; tick(); idle();
    wr_done = 1; tick(); idle();
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (d_pend[m] !== 1'b1) begin n_errors++; $display("FAIL midstall_pre[%0d] got %b want 1", m, d_pend[m]); end
    end
    #2 rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (d_vec(m) !== 36'({2'd0, 1'b1, 1'b0, 16'd0, 8'd0, 8'd0})) begin
        n_errors++; $display("FAIL async_reset[%0d] got %h want %h", m, d_vec(m), {2'd0, 1'b1, 1'b0, 16'd0, 8'd0, 8'd0});
      end
    end
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    wr_en = 1; wr_addr = 32'd7; wr_data = 8'h3C; tick(); idle();
    wr_done = 1; rd_frame_end = 1; tick(); idle();
    rd_addr = 32'd7; tick(); idle();
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (d_rd[m] !== 8'h3C || d_front[m] !== 2'd1) begin
        n_errors++; $display("FAIL post_reset_write[%0d] got %h front %0d want 3c 1", m, d_rd[m], d_front[m]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      wr_en = 1'($urandom); wr_addr = $urandom; wr_data = 8'($urandom); rd_addr = $urandom;
      wr_done = ($urandom_range(0, 5) == 0); rd_frame_end = ($urandom_range(0, 4) == 0);
      tick();
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if (d_vec(m) !== m_vec(m)) begin
          n_errors++; $display("FAIL random[%0d] cyc %0d got %h want %h", m, c, d_vec(m), m_vec(m));
        end
      end
    end
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prime();
    test_reset();
    test_front_untouched();
    test_double_stall();
    test_double_simul();
    test_triple_drop();
    test_triple_simul();
    test_drop_saturate();
    test_reset_midstall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
